// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer behind the pipelined FFT: frames arrive in bit-reversed
// index order and leave in natural bin order, one sample per clock without stalls.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int N = 8,
    parameter type complex_product_t = struct packed {
        logic signed [2*DATA_WIDTH-1:0] r;
        logic signed [2*DATA_WIDTH-1:0] i;
    }
) (
    input  logic                 clk,
    input  logic                 reset,
    input  complex_product_t     in_sample,
    input  logic                 in_valid,
    output logic                 in_ready,
    output complex_product_t     out_sample,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);
    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    complex_product_t bank [2][N];
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic             wb;
    logic             rb;
    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] rcnt;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_done;
    logic             rd_done;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] res;
        res = '0;
        for (int b = 0; b < LOG2N; b++) begin
            res[b] = v[LOG2N-1-b];
        end
        return res;
    endfunction

    assign in_ready   = !reset && !full[wb];
    assign out_valid  = full[rb];
    assign out_sample = bank[rb][rcnt];
    assign out_index  = rcnt;
    assign out_last   = full[rb] && (rcnt == LAST);

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_done = wr_fire && (wcnt == LAST);
    assign rd_done = rd_fire && (rcnt == LAST);

    // The set is applied after the clear so a same-bank collision leaves the bank full.
    always_comb begin
        full_next = full;
        if (rd_done) begin
            full_next[rb] = 1'b0;
        end
        if (wr_done) begin
            full_next[wb] = 1'b1;
        end
    end

    // Sample storage is deliberately left out of reset; the full flags guard it.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank[wb][bitrev(wcnt)] <= in_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            full <= full_next;
            if (wr_fire) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST) begin
                    wb <= ~wb;
                end
            end
            if (rd_fire) begin
                rcnt <= rcnt + 1'b1;
                if (rcnt == LAST) begin
                    rb <= ~rb;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: N=8 instance for the main scenarios,
// N=16 instance for the size sweep.
module tb_fft_bitrev_reorder;

    typedef struct packed {
        logic signed [31:0] r;
        logic signed [31:0] i;
    } cp_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    cp_t        in_sample;
    logic       in_valid;
    logic       in_ready;
    cp_t        out_sample;
    logic [2:0] out_index;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    logic       reset_16;
    cp_t        in_sample_16;
    logic       in_valid_16;
    logic       in_ready_16;
    cp_t        out_sample_16;
    logic [3:0] out_index_16;
    logic       out_valid_16;
    logic       out_ready_16;
    logic       out_last_16;

    fft_bitrev_reorder #(.DATA_WIDTH(16), .N(8), .complex_product_t(cp_t)) dut (
        .clk(clk), .reset(reset),
        .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
        .out_sample(out_sample), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    fft_bitrev_reorder #(.DATA_WIDTH(16), .N(16), .complex_product_t(cp_t)) dut_16 (
        .clk(clk), .reset(reset_16),
        .in_sample(in_sample_16), .in_valid(in_valid_16), .in_ready(in_ready_16),
        .out_sample(out_sample_16), .out_index(out_index_16), .out_valid(out_valid_16),
        .out_ready(out_ready_16), .out_last(out_last_16)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_count = 0;
    int   last_acc_cyc = 0;
    cp_t  feed_q[$];
    cp_t  got_s[$];
    int   got_idx[$];
    bit   got_last[$];
    int   got_cyc[$];
    bit   rdy_hist[$];
    bit   stalled = 1'b0;
    cp_t  held_s;
    int   held_idx;
    bit   held_last;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int brev(input int v, input int bits);
        int res = 0;
        for (int b = 0; b < bits; b++) begin
            if (v[b]) res |= (1 << (bits - 1 - b));
        end
        return res;
    endfunction

    // Arrival k of a frame carries natural bin brev(k), so bin n should come out as base+n.
    task automatic pushFrame(input int base);
        cp_t s;
        for (int k = 0; k < 8; k++) begin
            s.r = base + brev(k, 3);
            s.i = -s.r;
            feed_q.push_back(s);
        end
    endtask

    task automatic clearOutputs();
        got_s.delete();
        got_idx.delete();
        got_last.delete();
        got_cyc.delete();
        acc_count = 0;
    endtask

    task automatic checkFrame(input string tag, input int first, input int base);
        for (int n = 0; n < 8; n++) begin
            checkOutput({tag, "_r"}, got_s[first+n].r, base + n);
            checkOutput({tag, "_i"}, got_s[first+n].i, -(base + n));
            checkOutput({tag, "_idx"}, got_idx[first+n], n);
            checkOutput({tag, "_last"}, got_last[first+n], (n == 7) ? 1 : 0);
        end
    endtask

    // One clock cycle: drive inputs, check stall hold, log handshakes, advance to posedge+1.
    task automatic applyStimulus(input bit feed_en, input bit ordy);
        in_valid  = feed_en && (feed_q.size() > 0);
        in_sample = (feed_q.size() > 0) ? feed_q[0] : '0;
        out_ready = ordy;
        #2;
        rdy_hist.push_back(in_ready);
        if (stalled) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_sample", out_sample, held_s);
            checkOutput("stall_index", out_index, held_idx);
            checkOutput("stall_last", out_last, held_last);
        end
        stalled   = out_valid && !out_ready && !reset;
        held_s    = out_sample;
        held_idx  = out_index;
        held_last = out_last;
        if (in_valid && in_ready) begin
            void'(feed_q.pop_front());
            acc_count++;
            last_acc_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            got_s.push_back(out_sample);
            got_idx.push_back(out_index);
            got_last.push_back(out_last);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        cp_t s16;
        int  k16;
        int  n16;
        int  spin;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sample = '0;
        reset_16 = 1'b1; in_valid_16 = 1'b0; out_ready_16 = 1'b0; in_sample_16 = '0;
        @(posedge clk);
        #1;

        applyStimulus(0, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_out_index", out_index, 0);
        reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", in_ready, 1);

        // Single frame given as the literal bit-reversed sequence.
        clearOutputs();
        for (int k = 0; k < 8; k++) begin
            s16.r = (k[0] ? 4 : 0) + (k[1] ? 2 : 0) + (k[2] ? 1 : 0);
            s16.i = -s16.r;
            feed_q.push_back(s16);
        end
        spin = 0;
        while (acc_count < 8 && spin < 20) begin applyStimulus(1, 1); spin++; end
        checkOutput("single_no_early_out", got_s.size(), 0);
        checkOutput("single_latency_valid", out_valid, 1);
        checkOutput("single_latency_index", out_index, 0);
        spin = 0;
        while (got_s.size() < 8 && spin < 20) begin applyStimulus(0, 1); spin++; end
        checkOutput("single_count", got_s.size(), 8);
        checkOutput("single_first_cycle", got_cyc[0], last_acc_cyc + 1);
        checkFrame("single", 0, 0);

        // Four back-to-back frames with no backpressure.
        clearOutputs();
        for (int f = 0; f < 4; f++) pushFrame(32 + 16 * f);
        for (int c = 0; c < 32; c++) applyStimulus(1, 1);
        checkOutput("stream_accepts", acc_count, 32);
        spin = 0;
        while (got_s.size() < 32 && spin < 40) begin applyStimulus(0, 1); spin++; end
        checkOutput("stream_count", got_s.size(), 32);
        checkOutput("stream_no_bubbles", got_cyc[31] - got_cyc[0], 31);
        for (int f = 0; f < 4; f++) checkFrame("stream", 8 * f, 32 + 16 * f);

        // Read side fully stalled: two banks fill, then the input is refused.
        clearOutputs();
        pushFrame(200); pushFrame(300); pushFrame(400);
        for (int c = 0; c < 20; c++) applyStimulus(1, 0);
        checkOutput("bp_accepts", acc_count, 16);
        checkOutput("bp_ready_low", in_ready, 0);
        feed_q.delete();
        spin = 0;
        while (got_s.size() < 16 && spin < 40) begin applyStimulus(0, 1); spin++; end
        checkOutput("bp_count", got_s.size(), 16);
        checkOutput("bp_ready_at_last", rdy_hist[got_cyc[7]], 0);
        checkOutput("bp_ready_after_last", rdy_hist[got_cyc[7] + 1], 1);
        checkFrame("bp_f0", 0, 200);
        checkFrame("bp_f1", 8, 300);

        // Pseudo-random consumer stalls.
        clearOutputs();
        pushFrame(500); pushFrame(600);
        spin = 0;
        while (got_s.size() < 16 && spin < 300) begin
            applyStimulus(1, 1'($urandom_range(0, 1)));
            spin++;
        end
        checkOutput("rand_count", got_s.size(), 16);
        checkFrame("rand_f0", 0, 500);
        checkFrame("rand_f1", 8, 600);

        // Reset with one full frame pending and a second frame partly written.
        clearOutputs();
        pushFrame(700); pushFrame(800);
        spin = 0;
        while (acc_count < 13 && spin < 30) begin applyStimulus(1, 0); spin++; end
        checkOutput("rst_pre_accepts", acc_count, 13);
        reset = 1'b1;
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("rst_valid_low", out_valid, 0);
        checkOutput("rst_ready_low", in_ready, 0);
        reset = 1'b0;
        feed_q.delete();
        clearOutputs();
        pushFrame(900);
        spin = 0;
        while (got_s.size() < 8 && spin < 40) begin applyStimulus(1, 1); spin++; end
        for (int c = 0; c < 4; c++) applyStimulus(0, 1);
        checkOutput("rst_count", got_s.size(), 8);
        checkOutput("rst_first_cycle", got_cyc[0], last_acc_cyc + 1);
        checkFrame("rst_fresh", 0, 900);

        // N=16 instance fed a bit-reversed ramp.
        @(posedge clk);
        #1;
        reset_16 = 1'b0;
        out_ready_16 = 1'b1;
        k16 = 0;
        n16 = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid_16 = (k16 < 16);
            s16.r = brev(k16, 4);
            s16.i = -s16.r;
            in_sample_16 = s16;
            #2;
            if (out_valid_16) begin
                checkOutput("n16_r", out_sample_16.r, n16);
                checkOutput("n16_idx", out_index_16, n16);
                checkOutput("n16_last", out_last_16, (n16 == 15) ? 1 : 0);
                n16++;
            end
            if (in_valid_16 && in_ready_16) k16++;
            @(posedge clk);
            #1;
        end
        checkOutput("n16_count", n16, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
